spi_boot_master: RTL and testbench
==================================

Name: spi_boot_master

Overview:
- Fabric-side single-bit SPI master that drives the PULPino SPI slave (spi_clk_i / spi_cs_i / spi_sdi0_i / spi_sdo0_o), replacing the PS7 SPI0 controller as the boot/debug loader path.
- Accepts 32-bit word read/write requests on a valid/ready interface.
- Serialises each request as command byte + 32-bit address + 32-bit data, with dummy cycles before read data.
- Instantiated in the emulation top between the PS-side request source and the pulpino instance.

Parameters:
- CLK_DIV, 4, half-period of spi_sck_o in clk cycles; legal range 1..255.
- DUMMY_CYCLES, 32, SCK cycles between address and read data on reads.
- CMD_WRITE, 8'h02, command byte sent for writes.
- CMD_READ, 8'h0B, command byte sent for reads.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid_i  input  1  request valid.
- req_ready_o  output  1  request accepted when valid and ready are both high.
- req_write_i  input  1  1 = write, 0 = read.
- req_addr_i  input  32  target word address.
- req_wdata_i  input  32  write data.
- rsp_valid_o  output  1  one-cycle pulse at the end of every transaction (read and write).
- rsp_rdata_o  output  32  read data; 0 after a write.
- busy_o  output  1  high from acceptance until return to IDLE.
- spi_sck_o  output  1  SPI clock, mode 0 (idles low).
- spi_csn_o  output  1  chip select, active low.
- spi_mosi_o  output  1  serial data to slave.
- spi_miso_i  input  1  serial data from slave.

Behaviour:
- Reset (synchronous, active-high): the following hold on the first clk edge with rst high and override any transaction in flight:
  - state = IDLE
  - spi_csn_o = 1, spi_sck_o = 0, spi_mosi_o = 0
  - req_ready_o = 0 during reset, 1 in the first cycle after reset deasserts
  - rsp_valid_o = 0, rsp_rdata_o = 0, busy_o = 0
- Handshake:
  - req_ready_o = 1 only in IDLE.
  - On acceptance, latch write, addr and wdata, and enter CS_SETUP on the next cycle.
  - Request inputs are ignored while not in IDLE.
- Clock generation:
  - A tick counter counts 0..CLK_DIV-1; each wrap is one half-period.
  - spi_sck_o toggles only in the SHIFT states.
  - MOSI is updated while SCK is low, before the rising edge.
  - MISO is sampled on the clk cycle in which SCK rises.
  - MSB first everywhere.
- State machine (each SHIFT state is a bit counter of the given length):
  - IDLE -> CS_SETUP on acceptance.
  - CS_SETUP: csn = 0, present the command MSB on MOSI, hold one half-period -> CMD.
  - CMD: 8 bits -> ADDR.
  - ADDR: 32 bits -> WDATA if write; -> DUMMY if read and DUMMY_CYCLES > 0; -> RDATA if read and DUMMY_CYCLES = 0.
  - WDATA: 32 bits -> CS_HOLD.
  - DUMMY: DUMMY_CYCLES SCK cycles with MOSI = 0 -> RDATA.
  - RDATA: 32 bits; shift MISO into the rdata register; MOSI = 0 -> CS_HOLD.
  - CS_HOLD: SCK low, csn still 0, one half-period -> GAP.
  - GAP: csn = 1 for one half-period; rsp_valid_o pulses 1 cycle on the GAP->IDLE transition; rsp_rdata_o updates in the same cycle -> IDLE.
- Transaction timing:
  - One SCK cycle = 2*CLK_DIV clk cycles.
  - Write: 72 SCK cycles.
  - Read: 72 + DUMMY_CYCLES SCK cycles.
  - Acceptance to rsp_valid_o: (2*N_sck + 3)*CLK_DIV + 1 clk cycles, where N_sck is the SCK cycle count above.
- Boundary conditions:
  - req_valid_i asserted in the rsp_valid_o cycle is accepted on the following cycle (IDLE); no back-to-back acceptance without the GAP.
  - CLK_DIV = 1: SCK = clk/2; all rules above still hold.
  - rst mid-transaction: csn returns to 1 immediately on the reset edge; no rsp_valid_o for the aborted request.
  - MISO is ignored outside RDATA.

Test Plan:
1. Write addr 32'h0010_0000, data 32'hDEAD_BEEF, CLK_DIV=4 -> MOSI bitstream 02 00100000 DEADBEEF (72 bits) within one csn-low window; rsp_valid_o after (2*72+3)*4+1 = 589 clk cycles; rsp_rdata_o = 0.
2. Read addr 32'h0000_0004, slave model drives MISO 32'hCAFE_F00D after 32 dummy cycles -> rsp_rdata_o = 32'hCAFE_F00D; 104 SCK rising edges counted.
3. Read with DUMMY_CYCLES=0, CLK_DIV=1 -> 72 SCK cycles, SCK period = 2 clk, correct rdata 32'h1234_5678.
4. req_valid_i held high for 3 writes -> exactly 3 acceptances; csn high ≥ CLK_DIV cycles between frames; 3 rsp_valid_o pulses.
5. rst asserted at SCK edge 20 of a write -> next cycle csn=1, sck=0, busy_o=0, no rsp_valid_o; the next request completes normally.
6. Toggle MISO outside RDATA -> rsp_rdata_o unaffected; checker confirms MOSI is stable across every SCK rising edge.

Source files
------------

// File: rtl/spi_boot_master.sv
// spi_boot_master
//   Single-bit SPI master (mode 0, MSB first) that turns 32-bit word read/write
//   requests into frames for the PULPino SPI slave:
//     command byte, 32-bit address, then 32-bit write data
//     or DUMMY_CYCLES idle clocks followed by 32-bit read data.
//
// Ports
//   clk, rst       system clock, synchronous active-high reset
//   req_*_i/_o     valid/ready request channel (write flag, address, write data)
//   rsp_valid_o    one-cycle pulse when a frame completes
//   rsp_rdata_o    read data of the last transaction (0 after a write)
//   busy_o         transaction in flight
//   spi_*          SPI pins (sck idles low, csn active low)
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | waiting for a request, csn high
// CS_SETUP  | csn low, command MSB on mosi, one half-period
// CMD       | shifting the 8-bit command
// ADDR      | shifting the 32-bit address
// WDATA     | shifting the 32-bit write data
// DUMMY     | DUMMY_CYCLES sck cycles, mosi low
// RDATA     | 32 sck cycles sampling miso, mosi low
// CS_HOLD   | sck low, csn still low, one half-period
// GAP       | csn high for one half-period, then response pulse

module spi_boot_master #(
  parameter int unsigned CLK_DIV      = 4,
  parameter int unsigned DUMMY_CYCLES = 32,
  parameter logic [7:0]  CMD_WRITE    = 8'h02,
  parameter logic [7:0]  CMD_READ     = 8'h0B
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        busy_o,
  output logic        spi_sck_o,
  output logic        spi_csn_o,
  output logic        spi_mosi_o,
  input  logic        spi_miso_i
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CS_SETUP,
    S_CMD,
    S_ADDR,
    S_WDATA,
    S_DUMMY,
    S_RDATA,
    S_CS_HOLD,
    S_GAP
  } state_e;

  localparam logic [7:0]  TICK_LAST  = 8'(CLK_DIV - 1);
  localparam logic [15:0] DUMMY_LAST = (DUMMY_CYCLES != 0) ? 16'(DUMMY_CYCLES - 1) : 16'd0;

  state_e      state_q;
  logic [7:0]  tick_q;
  logic [15:0] bit_cnt_q;
  logic [31:0] sr_q;
  logic [31:0] rx_q;
  logic        write_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        ready_q;
  logic        rsp_valid_q;
  logic [31:0] rdata_q;
  logic        busy_q;
  logic        sck_q;
  logic        csn_q;
  logic        mosi_q;

  logic tick_wrap;
  logic in_shift;
  logic sck_fall;
  logic bit_done;
  logic accept;

  assign tick_wrap = (tick_q == TICK_LAST);
  assign in_shift  = (state_q == S_CMD) || (state_q == S_ADDR) || (state_q == S_WDATA) ||
                     (state_q == S_DUMMY) || (state_q == S_RDATA);
  assign sck_fall  = in_shift && tick_wrap && sck_q;
  // last falling edge of the current shift phase: time to move on
  assign bit_done  = sck_fall && (bit_cnt_q == 16'd0);
  assign accept    = (state_q == S_IDLE) && ready_q && req_valid_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      tick_q      <= 8'd0;
      bit_cnt_q   <= 16'd0;
      sr_q        <= 32'd0;
      rx_q        <= 32'd0;
      write_q     <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 32'd0;
      busy_q      <= 1'b0;
      sck_q       <= 1'b0;
      csn_q       <= 1'b1;
      mosi_q      <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;

      // every non-idle state lasts a whole number of half-periods, so a
      // free-running tick stays aligned across state changes
      if (state_q == S_IDLE || tick_wrap) tick_q <= 8'd0;
      else                                tick_q <= tick_q + 8'd1;

      if (in_shift && tick_wrap) sck_q <= ~sck_q;

      // next bit goes out on the falling edge so it is settled before the rise
      if (sck_fall && bit_cnt_q != 16'd0) begin
        bit_cnt_q <= bit_cnt_q - 16'd1;
        sr_q      <= {sr_q[30:0], 1'b0};
        mosi_q    <= sr_q[30];
      end

      if (state_q == S_RDATA && tick_wrap && !sck_q) rx_q <= {rx_q[30:0], spi_miso_i};

      case (state_q)
        S_IDLE: begin
          ready_q <= 1'b1;
          if (accept) begin
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            write_q <= req_write_i;
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
            rx_q    <= 32'd0;
            csn_q   <= 1'b0;
            sr_q    <= {(req_write_i ? CMD_WRITE : CMD_READ), 24'd0};
            mosi_q  <= req_write_i ? CMD_WRITE[7] : CMD_READ[7];
            state_q <= S_CS_SETUP;
          end
        end
        S_CS_SETUP: begin
          if (tick_wrap) begin
            bit_cnt_q <= 16'd7;
            state_q   <= S_CMD;
          end
        end
        S_CMD: begin
          if (bit_done) begin
            sr_q      <= addr_q;
            mosi_q    <= addr_q[31];
            bit_cnt_q <= 16'd31;
            state_q   <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (bit_done) begin
            if (write_q) begin
              sr_q      <= wdata_q;
              mosi_q    <= wdata_q[31];
              bit_cnt_q <= 16'd31;
              state_q   <= S_WDATA;
            end else begin
              sr_q   <= 32'd0;
              mosi_q <= 1'b0;
              if (DUMMY_CYCLES != 0) begin
                bit_cnt_q <= DUMMY_LAST;
                state_q   <= S_DUMMY;
              end else begin
                bit_cnt_q <= 16'd31;
                state_q   <= S_RDATA;
              end
            end
          end
        end
        S_WDATA: begin
          if (bit_done) begin
            mosi_q  <= 1'b0;
            state_q <= S_CS_HOLD;
          end
        end
        S_DUMMY: begin
          if (bit_done) begin
            bit_cnt_q <= 16'd31;
            state_q   <= S_RDATA;
          end
        end
        S_RDATA: begin
          if (bit_done) state_q <= S_CS_HOLD;
        end
        S_CS_HOLD: begin
          if (tick_wrap) begin
            csn_q   <= 1'b1;
            state_q <= S_GAP;
          end
        end
        S_GAP: begin
          if (tick_wrap) begin
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b1;
            rdata_q     <= write_q ? 32'd0 : rx_q;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready_o = ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rdata_q;
  assign busy_o      = busy_q;
  assign spi_sck_o   = sck_q;
  assign spi_csn_o   = csn_q;
  assign spi_mosi_o  = mosi_q;

endmodule

// File: tb/tb_spi_boot_master.sv
module tb_spi_boot_master;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // dut0: CLK_DIV=4, DUMMY_CYCLES=32
  logic        valid0, ready0, write0, rspv0, busy0, sck0, csn0, mosi0, miso0;
  logic [31:0] addr0, wdata0, rdata0;
  // dut1: CLK_DIV=1, DUMMY_CYCLES=0
  logic        valid1, ready1, write1, rspv1, busy1, sck1, csn1, mosi1, miso1;
  logic [31:0] addr1, wdata1, rdata1;

  spi_boot_master #(.CLK_DIV(4), .DUMMY_CYCLES(32)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid_i(valid0), .req_ready_o(ready0), .req_write_i(write0),
    .req_addr_i(addr0), .req_wdata_i(wdata0),
    .rsp_valid_o(rspv0), .rsp_rdata_o(rdata0), .busy_o(busy0),
    .spi_sck_o(sck0), .spi_csn_o(csn0), .spi_mosi_o(mosi0), .spi_miso_i(miso0)
  );

  spi_boot_master #(.CLK_DIV(1), .DUMMY_CYCLES(0)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid_i(valid1), .req_ready_o(ready1), .req_write_i(write1),
    .req_addr_i(addr1), .req_wdata_i(wdata1),
    .rsp_valid_o(rspv1), .rsp_rdata_o(rdata1), .busy_o(busy1),
    .spi_sck_o(sck1), .spi_csn_o(csn1), .spi_mosi_o(mosi1), .spi_miso_i(miso1)
  );

  int passed = 0;
  int total  = 0;

  task automatic chk(input string nm, input logic [103:0] act, input logic [103:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // ---------------- monitors / slave models ----------------
  int cyc = 0;
  always @(posedge clk) cyc++;

  int           rise_cnt0 = 0, rise_cnt1 = 0;
  logic [103:0] mosi_cap0 = '0, mosi_cap1 = '0;
  logic [31:0]  slave_data0 = '0, slave_data1 = '0;
  logic         mosi_prev0 = 1'b0, mosi_prev1 = 1'b0;
  int           glitch0 = 0, glitch1 = 0;
  int           last_rise1 = 0, prev_rise1 = 0;

  always @(negedge csn0) begin rise_cnt0 = 0; mosi_cap0 = '0; end
  always @(negedge csn1) begin rise_cnt1 = 0; mosi_cap1 = '0; end

  always @(negedge clk) begin mosi_prev0 = mosi0; mosi_prev1 = mosi1; end

  always @(posedge sck0) begin
    if (mosi0 !== mosi_prev0) glitch0++;
    mosi_cap0 = {mosi_cap0[102:0], mosi0};
    rise_cnt0++;
  end
  always @(posedge sck1) begin
    if (mosi1 !== mosi_prev1) glitch1++;
    mosi_cap1 = {mosi_cap1[102:0], mosi1};
    rise_cnt1++;
    prev_rise1 = last_rise1;
    last_rise1 = cyc;
  end

  // slave drives read data in the RDATA window and toggles miso everywhere else
  always_comb begin
    miso0 = rise_cnt0[0];
    if (rise_cnt0 >= 72 && rise_cnt0 < 104) miso0 = slave_data0[5'(103 - rise_cnt0)];
  end
  always_comb begin
    miso1 = ~rise_cnt1[0];
    if (rise_cnt1 >= 40 && rise_cnt1 < 72) miso1 = slave_data1[5'(71 - rise_cnt1)];
  end

  int acc_cnt0 = 0, rsp_cnt0 = 0, ready_in_rsp0 = 0;
  int csn_run0 = 0, min_gap0 = 100000;
  always @(posedge clk) begin
    if (valid0 && ready0) acc_cnt0++;
    if (rspv0) rsp_cnt0++;
    if (rspv0 && ready0) ready_in_rsp0++;
    if (csn0) csn_run0++;
    else begin
      if (csn_run0 > 0 && csn_run0 < min_gap0) min_gap0 = csn_run0;
      csn_run0 = 0;
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic         wr;
    logic [31:0]  addr;
    logic [31:0]  wdata;
    logic [31:0]  sdata;
    logic [31:0]  exp_rdata;
    logic [103:0] exp_mosi;
    int           exp_lat;
    int           exp_rises;
  } vec_t;

  vec_t vecs[4];

  // one transaction on dut0, called and returning on a negedge
  task automatic run0(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] sd, input string nm, output int lat, output logic ok);
    int n;
    int t;
    ok = 1'b0;
    lat = 0;
    slave_data0 = sd;
    write0 = wr;
    addr0 = a;
    wdata0 = wd;
    valid0 = 1'b1;
    n = 0;
    while (!ready0 && n < 50) begin @(negedge clk); n++; end
    t = cyc;
    @(negedge clk);
    valid0 = 1'b0;
    chk({nm, " busy"}, 104'(busy0), 104'd1);
    n = 0;
    while (!rspv0 && n < 5000) begin @(negedge clk); n++; end
    ok = rspv0;
    lat = cyc - t;
  endtask

  int   lat;
  logic ok;
  int   n;
  int   t;
  int   nacc;
  int   base_acc, base_rsp;

  initial begin
    vecs[0] = '{1'b1, 32'h0010_0000, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'h0,
                {32'h0, 8'h02, 32'h0010_0000, 32'hDEAD_BEEF}, 589, 72};
    vecs[1] = '{1'b0, 32'h0000_0004, 32'h0, 32'hCAFE_F00D, 32'hCAFE_F00D,
                {8'h0B, 32'h0000_0004, 64'h0}, 845, 104};
    vecs[2] = '{1'b1, 32'hFFFF_FFFC, 32'h0000_0001, 32'h5555_5555, 32'h0,
                {32'h0, 8'h02, 32'hFFFF_FFFC, 32'h0000_0001}, 589, 72};
    vecs[3] = '{1'b0, 32'h8000_0000, 32'h1111_1111, 32'hA5A5_5A5A, 32'hA5A5_5A5A,
                {8'h0B, 32'h8000_0000, 64'h0}, 845, 104};

    rst = 1'b1;
    valid0 = 1'b0; write0 = 1'b0; addr0 = '0; wdata0 = '0;
    valid1 = 1'b0; write1 = 1'b0; addr1 = '0; wdata1 = '0;
    repeat (3) @(negedge clk);

    chk("rst csn",   104'(csn0),   104'd1);
    chk("rst sck",   104'(sck0),   104'd0);
    chk("rst mosi",  104'(mosi0),  104'd0);
    chk("rst ready", 104'(ready0), 104'd0);
    chk("rst rspv",  104'(rspv0),  104'd0);
    chk("rst rdata", 104'(rdata0), 104'd0);
    chk("rst busy",  104'(busy0),  104'd0);

    rst = 1'b0;
    @(negedge clk);
    chk("ready after rst", 104'(ready0), 104'd1);

    // table-driven transactions on dut0
    for (int i = 0; i < 4; i++) begin
      run0(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].sdata, $sformatf("v%0d", i), lat, ok);
      chk($sformatf("v%0d done", i),    104'(ok), 104'd1);
      chk($sformatf("v%0d rdata", i),   104'(rdata0), 104'(vecs[i].exp_rdata));
      chk($sformatf("v%0d latency", i), 104'(lat), 104'(vecs[i].exp_lat));
      chk($sformatf("v%0d rises", i),   104'(rise_cnt0), 104'(vecs[i].exp_rises));
      chk($sformatf("v%0d mosi", i),    mosi_cap0, vecs[i].exp_mosi);
      repeat (3) @(negedge clk);
    end

    // CLK_DIV=1, no dummy cycles
    slave_data1 = 32'h1234_5678;
    write1 = 1'b0;
    addr1 = 32'h0000_0008;
    valid1 = 1'b1;
    n = 0;
    while (!ready1 && n < 50) begin @(negedge clk); n++; end
    t = cyc;
    @(negedge clk);
    valid1 = 1'b0;
    n = 0;
    while (!rspv1 && n < 1000) begin @(negedge clk); n++; end
    chk("div1 done",    104'(rspv1), 104'd1);
    chk("div1 rdata",   104'(rdata1), 104'h1234_5678);
    chk("div1 latency", 104'(cyc - t), 104'd148);
    chk("div1 rises",   104'(rise_cnt1), 104'd72);
    chk("div1 period",  104'(last_rise1 - prev_rise1), 104'd2);
    chk("div1 mosi",    mosi_cap1, {32'h0, 8'h0B, 32'h0000_0008, 32'h0});

    // valid held for three back-to-back writes
    repeat (2) @(negedge clk);
    base_acc = acc_cnt0;
    base_rsp = rsp_cnt0;
    min_gap0 = 100000;
    write0 = 1'b1; addr0 = 32'h0000_0100; wdata0 = 32'h0BAD_F00D;
    valid0 = 1'b1;
    nacc = 0;
    n = 0;
    while (nacc < 3 && n < 3000) begin
      if (ready0) nacc++;
      @(negedge clk);
      n++;
    end
    valid0 = 1'b0;
    n = 0;
    while (rsp_cnt0 - base_rsp < 3 && n < 1000) begin @(negedge clk); n++; end
    repeat (10) @(negedge clk);
    chk("b2b accepts",     104'(acc_cnt0 - base_acc), 104'd3);
    chk("b2b responses",   104'(rsp_cnt0 - base_rsp), 104'd3);
    chk("b2b gap ok",      104'(min_gap0 >= 4), 104'd1);
    chk("ready in rsp",    104'(ready_in_rsp0), 104'd0);

    // reset in the middle of a write
    write0 = 1'b1; addr0 = 32'h0000_0200; wdata0 = 32'h1357_9BDF;
    valid0 = 1'b1;
    n = 0;
    while (!ready0 && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    valid0 = 1'b0;
    n = 0;
    while (rise_cnt0 < 20 && n < 500) begin @(negedge clk); n++; end
    chk("abort reached edge 20", 104'(rise_cnt0), 104'd20);
    base_rsp = rsp_cnt0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort csn",  104'(csn0),  104'd1);
    chk("abort sck",  104'(sck0),  104'd0);
    chk("abort busy", 104'(busy0), 104'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (700) @(negedge clk);
    chk("abort no rsp", 104'(rsp_cnt0 - base_rsp), 104'd0);
    run0(1'b0, 32'h0000_0040, 32'h0, 32'h0F0F_A5C3, "post", lat, ok);
    chk("post done",    104'(ok), 104'd1);
    chk("post rdata",   104'(rdata0), 104'h0F0F_A5C3);
    chk("post latency", 104'(lat), 104'd845);

    chk("mosi stable div4", 104'(glitch0), 104'd0);
    chk("mosi stable div1", 104'(glitch1), 104'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
